// File: rtl/pulse_width_controller_pkg.sv
// Shared state encoding for pulse_width_controller and its status-register decoder.
package pulse_width_controller_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/pulse_width_controller_edge_detect_core.sv
// Registered rise/fall pulse generator on an already-synchronized input d_s.
module edge_detect_core (
  input  logic clk,
  input  logic rst,
  input  logic d_s,
  output logic rise,
  output logic fall
);

  logic d_prev_q, d_prev_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  always_comb begin
    d_prev_d = d_s;
    rise_d   = d_s & ~d_prev_q;
    fall_d   = ~d_s & d_prev_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_prev_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      d_prev_q <= d_prev_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/pulse_width_controller.sv
// Measures the high time of one pulse on async input D after a start request.
// Optional macro GLITCH_FILTER_EN rejects pulses shorter than MIN_WIDTH and re-arms.
module pulse_width_controller
  import pulse_width_controller_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1000,
  parameter int MIN_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             D,
  input  logic             start,
  input  logic             ack,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] width,
  output logic             overflow,
  output logic             timeout
);

  localparam int TMO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  if (TIMEOUT < 1 || MIN_WIDTH < 1) begin : g_param_check
    $error("pulse_width_controller: TIMEOUT and MIN_WIDTH must be >= 1");
  end

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rise, fall;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             overflow_q, overflow_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    sync1_d = D;
    sync2_d = sync1_q;
  end

  edge_detect_core u_edge (
    .clk  (clk),
    .rst  (rst),
    .d_s  (sync2_q),
    .rise (rise),
    .fall (fall)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    tmo_cnt_d  = tmo_cnt_q;
    width_d    = width_q;
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ARMED;
          tmo_cnt_d  = '0;
          overflow_d = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      S_ARMED: begin
        if (rise) begin
          state_d = S_MEASURE;
          count_d = CNT_W'(1);
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d   = S_DONE;
          width_d   = '0;
          timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_MEASURE: begin
        if (!fall) begin
          // Hold at full scale; the overflow flag stays set until the next arm.
          if (count_q == CNT_MAX) overflow_d = 1'b1;
          else                    count_d    = count_q + 1'b1;
        end else begin
`ifdef GLITCH_FILTER_EN
          if (int'(count_q) < MIN_WIDTH) begin
            state_d = S_ARMED;
            count_d = '0;
          end else begin
            state_d = S_DONE;
            width_d = count_q;
          end
`else
          state_d = S_DONE;
          width_d = count_q;
`endif
        end
      end
      S_DONE: begin
        if (ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= S_IDLE;
      count_q    <= '0;
      tmo_cnt_q  <= '0;
      width_q    <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      count_q    <= count_d;
      tmo_cnt_q  <= tmo_cnt_d;
      width_q    <= width_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy     = (state_q == S_ARMED) || (state_q == S_MEASURE);
  assign valid    = (state_q == S_DONE);
  assign width    = width_q;
  assign overflow = overflow_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_pulse_width_controller.sv
// Self-checking bench for pulse_width_controller (small CNT_W and TIMEOUT to reach the corners).
module tb_pulse_width_controller;

  localparam int CW   = 4;
  localparam int TMO  = 20;
  localparam int MINW = 4;
  localparam int WMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          D;
  logic          start;
  logic          ack;
  logic          busy;
  logic          valid;
  logic [CW-1:0] width;
  logic          overflow;
  logic          timeout;

  int errors = 0;
  int checks = 0;

  pulse_width_controller #(
    .CNT_W     (CW),
    .TIMEOUT   (TMO),
    .MIN_WIDTH (MINW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .D        (D),
    .start    (start),
    .ack      (ack),
    .busy     (busy),
    .valid    (valid),
    .width    (width),
    .overflow (overflow),
    .timeout  (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: a high pulse of n cycles reads back as n, clipped to full scale.
  function automatic int model_width(input int n);
    return (n > WMAX) ? WMAX : n;
  endfunction

  function automatic bit model_overflow(input int n);
    return n > WMAX;
  endfunction

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic arm();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse(input int n);
    D = 1'b1;
    cycles(n);
    D = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; D = 1'b0; start = 1'b0; ack = 1'b0;
    #2 D = 1'b1;
    #1;
    checks++;
    if ({busy, valid, width, overflow, timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {busy, valid, width, overflow, timeout});
    end
    #2 D = 1'b0;
    #3 rst = 1'b1;
    cycles(3);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b valid=%b exp=0 0", busy, valid);
    end
  endtask

  task automatic test_basic();
    bit ok;
    arm();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy); end
    pulse(10);
    wait_valid(40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL basic_valid_timeout got=0 exp=1"); end
    cycles(2);
    checks++;
    if (valid !== 1'b1 || width !== CW'(10) || overflow !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result valid=%b width=%0d ovf=%b tmo=%b exp=1 10 0 0",
               valid, width, overflow, timeout);
    end
    do_ack();
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL basic_ack got=%b exp=0", valid); end
  endtask

  task automatic test_timeout();
    bit early;
    early = 1'b0;
    arm();
    for (int i = 1; i < TMO; i++) begin
      if (valid !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (early || valid !== 1'b0) begin
      errors++; $display("FAIL timeout_early got=1 exp=0");
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b1 || timeout !== 1'b1 || width !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_result valid=%b tmo=%b width=%0d busy=%b exp=1 1 0 0",
               valid, timeout, width, busy);
    end
    do_ack();
  endtask

  task automatic test_overflow();
    bit ok;
    arm();
    pulse(30);
    wait_valid(40, ok);
    checks++;
    if (!ok || width !== CW'(WMAX) || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow ok=%b width=%0d ovf=%b exp=1 %0d 1", ok, width, overflow, WMAX);
    end
    do_ack();
    cycles(3);
  endtask

  task automatic test_glitch();
    bit [12:0] pat;
    int rises, cap_w, exp_w;
    logic prev_v;
    pat = 13'b0_111111_000_11_0;
    rises = 0; cap_w = -1; prev_v = 1'b0;
`ifdef GLITCH_FILTER_EN
    exp_w = 6;
`else
    exp_w = 2;
`endif
    arm();
    for (int i = 0; i < 28; i++) begin
      D = (i < 13) ? pat[i] : 1'b0;
      @(negedge clk);
      if (valid === 1'b1 && prev_v !== 1'b1) begin
        rises++;
        if (cap_w < 0) cap_w = int'(width);
      end
      prev_v = valid;
    end
    checks++;
    if (rises !== 1 || cap_w !== exp_w) begin
      errors++;
      $display("FAIL glitch valid_events=%0d width=%0d exp=1 %0d", rises, cap_w, exp_w);
    end
    do_ack();
    cycles(3);
  endtask

  task automatic test_corners();
    bit ok, leak;
    // start while measuring must not restart the measurement
    arm();
    D = 1'b1;
    cycles(5);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(2);
    D = 1'b0;
    wait_valid(40, ok);
    checks++;
    if (!ok || width !== CW'(8)) begin
      errors++; $display("FAIL start_in_measure ok=%b width=%0d exp=1 8", ok, width);
    end
    do_ack();
    cycles(3);
    // input already high at arm: only the next 0->1 transition counts
    D = 1'b1;
    cycles(4);
    arm();
    cycles(4);
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++; $display("FAIL high_at_arm_wait busy=%b valid=%b exp=1 0", busy, valid);
    end
    D = 1'b0;
    cycles(3);
    pulse(7);
    wait_valid(40, ok);
    checks++;
    if (!ok || width !== CW'(7)) begin
      errors++; $display("FAIL high_at_arm ok=%b width=%0d exp=1 7", ok, width);
    end
    // start and ack together in DONE: ack wins, start is dropped
    @(negedge clk);
    start = 1'b1; ack = 1'b1;
    @(negedge clk);
    start = 1'b0; ack = 1'b0;
    leak = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || valid !== 1'b0) leak = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (leak) begin errors++; $display("FAIL start_ack_same got=active exp=idle"); end
    // reset pulse mid-measurement aborts with no result
    arm();
    D = 1'b1;
    cycles(6);
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, valid, width, overflow, timeout} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs got=%b exp=0", {busy, valid, width, overflow, timeout});
    end
    #2 rst = 1'b1;
    cycles(4);
    D = 1'b0;
    leak = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (valid !== 1'b0 || busy !== 1'b0) leak = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (leak) begin errors++; $display("FAIL rst_mid_no_result got=active exp=idle"); end
  endtask

  task automatic test_random();
    bit ok;
    int n, pre, lo;
    lo = 1;
`ifdef GLITCH_FILTER_EN
    lo = MINW;
`endif
    for (int it = 0; it < 10; it++) begin
      n   = int'($urandom_range(25, lo));
      pre = int'($urandom_range(5, 0));
      arm();
      cycles(pre);
      pulse(n);
      wait_valid(60, ok);
      checks++;
      if (!ok || width !== CW'(model_width(n)) || overflow !== model_overflow(n)
          || timeout !== 1'b0) begin
        errors++;
        $display("FAIL random_%0d n=%0d ok=%b width=%0d ovf=%b tmo=%b exp=1 %0d %b 0",
                 it, n, ok, width, overflow, timeout, model_width(n), model_overflow(n));
      end
      do_ack();
      cycles(4);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_overflow();
    test_glitch();
    test_corners();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=stuck exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
